// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic matrix-multiply front end.
package systolic_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StFeed,
        StDrain,
        StDone
    } sched_state_e;

    localparam int unsigned N_DEFAULT = 3;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int unsigned phase_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned PHASE_W = phase_w(N_DEFAULT);

endpackage

// File: rtl/systolic_feed_sched_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int unsigned Width = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] cnt_q;
    logic [Width-1:0] cnt_d;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {Width{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/systolic_feed_sched.sv
// Job scheduler for the systolic array: accepts multi-tile jobs, sequences the
// N-phase skewed operand feed per tile, drains the MAC pipeline, pulses done.
// Optional build macro SYSTOLIC_SCHED_PERF_EN enables the WAIT-cycle stall
// counter; without it stall_cnt_o is tied to zero.
module systolic_feed_sched
    import systolic_pkg::*;
#(
    parameter int unsigned N            = N_DEFAULT,
    parameter int unsigned DRAIN_CYCLES = 2 * N,
    parameter int unsigned TILE_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  job_valid_i,
    output logic                  job_ready_o,
    input  logic [TILE_W-1:0]     job_tiles_i,
    input  logic                  tile_valid_i,
    output logic                  tile_ack_o,
    input  logic                  abort_i,
    output logic                  feed_en_o,
    output logic [phase_w(N)-1:0] feed_phase_o,
    output logic                  a_row_sel_o,
    output logic                  b_row_sel_o,
    output logic                  acc_clr_o,
    output logic                  mac_en_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [15:0]           stall_cnt_o
);

    localparam int unsigned PhaseW = phase_w(N);
    localparam int unsigned DrainW = phase_w(DRAIN_CYCLES);
    localparam logic [PhaseW-1:0] LastPhase = PhaseW'(N - 1);
    localparam logic [DrainW-1:0] DrainLoad = DrainW'(DRAIN_CYCLES - 1);

    sched_state_e      state_q;
    logic [PhaseW-1:0] phase_q;
    logic [TILE_W-1:0] tiles_q;
    logic [DrainW-1:0] drain_q;
    logic              first_q;

    logic in_feed;
    logic last_phase;

    assign in_feed    = (state_q == StFeed);
    assign last_phase = (phase_q == LastPhase);

    // Scheduler FSM with its phase, tile and drain counters; abort beats everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            phase_q <= '0;
            tiles_q <= '0;
            drain_q <= '0;
            first_q <= 1'b0;
        end else if (abort_i && (state_q != StIdle)) begin
            state_q <= StIdle;
            phase_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (job_valid_i) begin
                        // A zero tile count runs as a single tile.
                        tiles_q <= (job_tiles_i == '0) ? TILE_W'(1) : job_tiles_i;
                        first_q <= 1'b1;
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (tile_valid_i) begin
                        phase_q <= '0;
                        state_q <= StFeed;
                    end
                end
                StFeed: begin
                    // Accumulator clear only belongs to phase 0 of the first tile.
                    first_q <= 1'b0;
                    if (last_phase) begin
                        phase_q <= '0;
                        tiles_q <= tiles_q - 1'b1;
                        if (tiles_q == TILE_W'(1)) begin
                            drain_q <= DrainLoad;
                            state_q <= StDrain;
                        end else if (!tile_valid_i) begin
                            state_q <= StWait;
                        end
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                StDrain: begin
                    if (drain_q == '0) begin
                        state_q <= StDone;
                    end else begin
                        drain_q <= drain_q - 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Outputs decode registered state only; job_ready has no input dependence either.
    assign job_ready_o  = (state_q == StIdle);
    assign busy_o       = (state_q != StIdle);
    assign feed_en_o    = in_feed;
    assign feed_phase_o = in_feed ? phase_q : '0;
    assign tile_ack_o   = in_feed && last_phase;
    assign acc_clr_o    = in_feed && (phase_q == '0) && first_q;
    assign mac_en_o     = in_feed || (state_q == StDrain);
    assign done_o       = (state_q == StDone);
    assign a_row_sel_o  = 1'b1;
    assign b_row_sel_o  = 1'b0;

`ifdef SYSTOLIC_SCHED_PERF_EN
    logic stall_clr;
    logic stall_inc;

    assign stall_clr = (state_q == StIdle) && job_valid_i;
    assign stall_inc = (state_q == StWait);

    sat_counter #(
        .Width(16)
    ) u_stall_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr_i(stall_clr),
        .inc_i(stall_inc),
        .cnt_o(stall_cnt_o)
    );
`else
    assign stall_cnt_o = 16'h0000;
`endif

endmodule
